key_debounce_sync: RTL and testbench

- Front-end conditioning stage for the 4-bit pushbutton/key inputs that drive the input PIO's `in_port`.
- Synchronises raw asynchronous board keys into `clk`, debounces each channel independently, and converts active-low keys to clean active-high levels.
- Also produces single-cycle press/release pulses.
- `btn_level` connects directly to the PIO data input, so PIO interrupts fire only on stable, glitch-free levels.

---
 rtl/key_debounce_sync.sv | 91 +++++++++
 tb/tb_key_debounce_sync.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_sync.sv
// Key input conditioning: 2-flop sync, per-channel debounce, press/release pulses.
// Optional sticky press capture enabled with `define KEY_STICKY_CAPTURE_EN.
module key_debounce_sync #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
`ifdef KEY_STICKY_CAPTURE_EN
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
`endif
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [WIDTH-1:0]         norm;
  logic [WIDTH-1:0]         s1_q, s2_q;
  logic [WIDTH-1:0]         lvl_q, lvl_d;
  logic [WIDTH-1:0]         press_q, press_d;
  logic [WIDTH-1:0]         rel_q, rel_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  assign norm = key_raw ^ {WIDTH{POL}};

  // A channel only counts while its synced input disagrees with the level.
  always_comb begin
    lvl_d   = lvl_q;
    press_d = '0;
    rel_d   = '0;
    cnt_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == LAST) begin
          lvl_d[i]   = s2_q[i];
          press_d[i] = s2_q[i];
          rel_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= norm;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level   = lvl_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

`ifdef KEY_STICKY_CAPTURE_EN
  logic [WIDTH-1:0] cap_q, cap_d;

  // Set has priority over a same-cycle clear.
  assign cap_d = (cap_q & ~edge_clear) | press_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign edge_capture = cap_q;
`endif

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_key_debounce_sync;

  logic       clk;
  logic       reset;
  logic [3:0] key_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
`ifdef KEY_STICKY_CAPTURE_EN
  logic [3:0] edge_clear;
  logic [3:0] edge_capture;
`endif

  int errors = 0;
  int checks = 0;

  key_debounce_sync #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
`ifdef KEY_STICKY_CAPTURE_EN
    .edge_clear(edge_clear),
    .edge_capture(edge_capture),
`endif
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] seen;
    key_raw = 4'hF;
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (btn_level !== 4'h0 || btn_press !== 4'h0 || btn_release !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: lvl=%h prs=%h rel=%h required 0 0 0",
               btn_level, btn_press, btn_release);
    end
`ifdef KEY_STICKY_CAPTURE_EN
    checks++;
    if (edge_capture !== 4'h0) begin
      errors++;
      $display("FAIL reset_capture: got %h required 0", edge_capture);
    end
`endif
    reset = 1'b0;
    seen = 4'h0;
    repeat (50) begin
      tick();
      seen = seen | btn_level | btn_press | btn_release;
    end
    checks++;
    if (seen !== 4'h0) begin
      errors++;
      $display("FAIL idle_quiet: activity=%h required 0", seen);
    end
  endtask

  task automatic test_clean_press();
    key_raw = 4'hE;
    repeat (5) tick();
    checks++;
    if (btn_level !== 4'h0) begin
      errors++;
      $display("FAIL press_early: lvl=%h required 0 after 5 edges", btn_level);
    end
    tick();
    checks++;
    if (btn_level !== 4'h1 || btn_press !== 4'h1 || btn_release !== 4'h0) begin
      errors++;
      $display("FAIL press_accept: lvl=%h prs=%h rel=%h required 1 1 0",
               btn_level, btn_press, btn_release);
    end
    tick();
    checks++;
    if (btn_press !== 4'h0 || btn_level !== 4'h1) begin
      errors++;
      $display("FAIL press_one_cycle: prs=%h lvl=%h required 0 1",
               btn_press, btn_level);
    end
    key_raw = 4'hF;
    repeat (5) tick();
    checks++;
    if (btn_level !== 4'h1 || btn_release !== 4'h0) begin
      errors++;
      $display("FAIL release_early: lvl=%h rel=%h required 1 0",
               btn_level, btn_release);
    end
    tick();
    checks++;
    if (btn_level !== 4'h0 || btn_release !== 4'h1 || btn_press !== 4'h0) begin
      errors++;
      $display("FAIL release_accept: lvl=%h rel=%h prs=%h required 0 1 0",
               btn_level, btn_release, btn_press);
    end
    tick();
    checks++;
    if (btn_release !== 4'h0) begin
      errors++;
      $display("FAIL release_one_cycle: rel=%h required 0", btn_release);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] seen;
    logic [3:0] prs_or;
    int         npress;
    int         lows [4] = '{3, 2, 0, 0};
    int         highs[4] = '{1, 2, 0, 0};
    seen = 4'h0;
    for (int p = 0; p < 2; p++) begin
      key_raw = 4'hB;
      for (int k = 0; k < lows[p]; k++) begin
        tick();
        seen = seen | btn_level | btn_press | btn_release;
      end
      key_raw = 4'hF;
      for (int k = 0; k < highs[p]; k++) begin
        tick();
        seen = seen | btn_level | btn_press | btn_release;
      end
    end
    repeat (6) begin
      tick();
      seen = seen | btn_level | btn_press | btn_release;
    end
    checks++;
    if (seen !== 4'h0) begin
      errors++;
      $display("FAIL bounce_reject: activity=%h required 0", seen);
    end
    key_raw = 4'hB;
    npress = 0;
    prs_or = 4'h0;
    repeat (10) begin
      tick();
      if (btn_press != 4'h0) npress++;
      prs_or = prs_or | btn_press;
    end
    checks++;
    if (npress !== 1 || prs_or !== 4'h4 || btn_level !== 4'h4) begin
      errors++;
      $display("FAIL bounce_then_hold: pulses=%0d bits=%h lvl=%h required 1 4 4",
               npress, prs_or, btn_level);
    end
    key_raw = 4'hF;
    repeat (8) tick();
    checks++;
    if (btn_level !== 4'h0) begin
      errors++;
      $display("FAIL bounce_release: lvl=%h required 0", btn_level);
    end
  endtask

  task automatic test_multi();
    key_raw = 4'h5;
    repeat (5) tick();
    checks++;
    if (btn_level !== 4'h0 || btn_press !== 4'h0) begin
      errors++;
      $display("FAIL multi_early: lvl=%h prs=%h required 0 0", btn_level, btn_press);
    end
    tick();
    checks++;
    if (btn_level !== 4'hA || btn_press !== 4'hA) begin
      errors++;
      $display("FAIL multi_accept: lvl=%h prs=%h required a a", btn_level, btn_press);
    end
    tick();
    checks++;
    if (btn_press !== 4'h0) begin
      errors++;
      $display("FAIL multi_one_cycle: prs=%h required 0", btn_press);
    end
    key_raw = 4'hF;
    repeat (6) tick();
    checks++;
    if (btn_level !== 4'h0 || btn_release !== 4'hA) begin
      errors++;
      $display("FAIL multi_release: lvl=%h rel=%h required 0 a",
               btn_level, btn_release);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] seen;
    key_raw = 4'hD;
    repeat (4) tick();
    reset = 1'b1;
    seen = 4'h0;
    repeat (3) begin
      tick();
      seen = seen | btn_press | btn_level;
    end
    checks++;
    if (seen !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity=%h required 0", seen);
    end
    reset = 1'b0;
    seen = 4'h0;
    repeat (5) begin
      tick();
      seen = seen | btn_press;
    end
    checks++;
    if (seen !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_early: prs=%h required 0", seen);
    end
    tick();
    checks++;
    if (btn_press !== 4'h2 || btn_level !== 4'h2) begin
      errors++;
      $display("FAIL reset_mid_accept: prs=%h lvl=%h required 2 2",
               btn_press, btn_level);
    end
    key_raw = 4'hF;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef KEY_STICKY_CAPTURE_EN
  task automatic test_sticky();
    edge_clear = 4'hF;
    tick();
    edge_clear = 4'h0;
    key_raw = 4'h7;
    repeat (6) tick();
    checks++;
    if (btn_press !== 4'h8 || edge_capture !== 4'h0) begin
      errors++;
      $display("FAIL sticky_pulse: prs=%h cap=%h required 8 0",
               btn_press, edge_capture);
    end
    tick();
    checks++;
    if (edge_capture !== 4'h8) begin
      errors++;
      $display("FAIL sticky_set: cap=%h required 8", edge_capture);
    end
    key_raw = 4'hF;
    repeat (7) tick();
    key_raw = 4'h7;
    repeat (6) tick();
    edge_clear = 4'h8;
    tick();
    checks++;
    if (edge_capture !== 4'h8) begin
      errors++;
      $display("FAIL sticky_set_wins: cap=%h required 8", edge_capture);
    end
    edge_clear = 4'h0;
    tick();
    edge_clear = 4'h8;
    tick();
    edge_clear = 4'h0;
    checks++;
    if (edge_capture !== 4'h0) begin
      errors++;
      $display("FAIL sticky_clear: cap=%h required 0", edge_capture);
    end
    tick();
    checks++;
    if (edge_capture !== 4'h0) begin
      errors++;
      $display("FAIL sticky_stays_clear: cap=%h required 0", edge_capture);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    key_raw = 4'hF;
`ifdef KEY_STICKY_CAPTURE_EN
    edge_clear = 4'h0;
`endif
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_reset_mid();
`ifdef KEY_STICKY_CAPTURE_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
